// File: rtl/uart_rx_fifo.sv
// Receive-side character FIFO between a UART receive engine and a byte-wide host port.
// Captures on RX_STATUS rising edges, acknowledges the engine, and serves data/status reads.
module uart_rx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       RX_STATUS,
   input  logic [7:0] UART_DATA,
   input  logic       PERR,
   input  logic       FERR,
   input  logic       OVF,
   input  logic       READ_STROBE,
   input  logic [3:0] PORT_ID,
   output logic [7:0] RD_DATA,
   output logic       reads_0,
   output logic       EMPTY,
   output logic       FULL,
   output logic       RX_INT
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   // Host handshake: READ_STROBE qualifies PORT_ID for exactly the cycle it is high;
   // RD_DATA is valid from the following edge and holds until the next valid read.

   logic [10:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          rx_status_q;
   logic          drop_q, drop_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          reads_0_q;

   logic          capture, data_rd, stat_rd;
   logic          push, pop, discard;
   logic          empty, full;
   logic [10:0]   head;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign head    = mem_q[rd_ptr_q];

   assign capture = RX_STATUS & ~rx_status_q;
   assign data_rd = READ_STROBE && (PORT_ID == 4'd0);
   assign stat_rd = READ_STROBE && (PORT_ID == 4'd1);
   assign pop     = data_rd && !empty;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the new entry.
   assign push    = capture && (!full || pop);
   assign discard = capture && full && !pop;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      drop_d    = drop_q;
      rd_data_d = rd_data_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (discard)      drop_d = 1'b1;
      else if (stat_rd) drop_d = 1'b0;

      if (data_rd) begin
         rd_data_d = empty ? 8'h00 : head[7:0];
      end else if (stat_rd) begin
         rd_data_d = {2'b00, drop_q, (empty ? 3'b000 : head[10:8]), full, ~empty};
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         drop_q      <= 1'b0;
         rd_data_q   <= 8'h00;
         reads_0_q   <= 1'b0;
         rx_status_q <= 1'b1;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         drop_q      <= drop_d;
         rd_data_q   <= rd_data_d;
         reads_0_q   <= capture;
         rx_status_q <= RX_STATUS;
      end
   end

   // Storage is not reset; occupancy is tracked solely by the pointers and count.
   always_ff @(posedge CLK) begin
      if (!RESET && push) begin
         mem_q[wr_ptr_q] <= {OVF, FERR, PERR, UART_DATA};
      end
   end

   assign RD_DATA = rd_data_q;
   assign reads_0 = reads_0_q;
   assign EMPTY   = empty;
   assign FULL    = full;
   assign RX_INT  = ~empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: host read data is checked by a queue-based scoreboard,
// flags and engine-acknowledge pulses by direct checks.
module tb_uart_rx_fifo;

   logic       CLK;
   logic       RESET;
   logic       RX_STATUS;
   logic [7:0] UART_DATA;
   logic       PERR, FERR, OVF;
   logic       READ_STROBE;
   logic [3:0] PORT_ID;
   logic [7:0] RD_DATA;
   logic       reads_0;
   logic       EMPTY, FULL, RX_INT;

   uart_rx_fifo #(.DEPTH(8)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .RX_STATUS   (RX_STATUS),
      .UART_DATA   (UART_DATA),
      .PERR        (PERR),
      .FERR        (FERR),
      .OVF         (OVF),
      .READ_STROBE (READ_STROBE),
      .PORT_ID     (PORT_ID),
      .RD_DATA     (RD_DATA),
      .reads_0     (reads_0),
      .EMPTY       (EMPTY),
      .FULL        (FULL),
      .RX_INT      (RX_INT)
   );

   int n_vec  = 0;
   int n_miss = 0;
   int pulse_cnt = 0;
   int pulse_run = 0;
   int pulse_max = 0;
   logic [7:0] exp_q [$];

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: compares RD_DATA one cycle after every valid host read
   initial begin
      logic take;
      logic [7:0] e;
      forever begin
         @(posedge CLK);
         take = (RESET === 1'b0) && (READ_STROBE === 1'b1) && (PORT_ID < 4'd2);
         @(negedge CLK);
         if (take) begin
            if (exp_q.size() == 0) begin
               chk("rd_unexpected", 32'(RD_DATA), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", 32'(RD_DATA), 32'(e));
            end
         end
      end
   end

   // reads_0 pulse counter and run-length tracker
   always @(negedge CLK) begin
      if (reads_0 === 1'b1) begin
         pulse_cnt++;
         pulse_run++;
         if (pulse_run > pulse_max) pulse_max = pulse_run;
      end else begin
         pulse_run = 0;
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send_char(input logic [7:0] d, input logic p, input logic f, input logic o);
      @(negedge CLK);
      UART_DATA = d; PERR = p; FERR = f; OVF = o;
      RX_STATUS = 1'b1;
      @(negedge CLK);
      RX_STATUS = 1'b0;
   endtask

   task automatic host_read(input logic [3:0] port, input logic [7:0] exp, input logic has_exp);
      @(negedge CLK);
      READ_STROBE = 1'b1;
      PORT_ID = port;
      if (has_exp) exp_q.push_back(exp);
      @(negedge CLK);
      READ_STROBE = 1'b0;
      PORT_ID = 4'd0;
   endtask

   initial begin
      int p0;
      int budget;
      RESET = 1'b1; RX_STATUS = 1'b1; UART_DATA = 8'h00;
      PERR = 1'b0; FERR = 1'b0; OVF = 1'b0;
      READ_STROBE = 1'b0; PORT_ID = 4'd0;
      tick(2);
      RESET = 1'b0;
      tick(3);
      chk("reset_rd_data", 32'(RD_DATA), 32'h00);
      chk("reset_empty", 32'(EMPTY), 32'd1);
      chk("reset_full", 32'(FULL), 32'd0);
      chk("reset_rx_int", 32'(RX_INT), 32'd0);
      chk("rx_high_release_no_pulse", 32'(pulse_cnt), 32'd0);
      RX_STATUS = 1'b0;

      host_read(4'd0, 8'h00, 1'b1);
      tick(1);
      chk("empty_read_empty", 32'(EMPTY), 32'd1);

      // basic path
      p0 = pulse_cnt;
      send_char(8'h41, 1'b0, 1'b0, 1'b0);
      tick(1);
      chk("basic_pulse", 32'(pulse_cnt - p0), 32'd1);
      chk("basic_empty", 32'(EMPTY), 32'd0);
      chk("basic_rx_int", 32'(RX_INT), 32'd1);
      host_read(4'd0, 8'h41, 1'b1);
      tick(1);
      chk("basic_empty_after", 32'(EMPTY), 32'd1);

      // error flags
      send_char(8'h5A, 1'b1, 1'b1, 1'b0);
      host_read(4'd1, 8'h0D, 1'b1);
      host_read(4'd0, 8'h5A, 1'b1);

      // overflow
      p0 = pulse_cnt;
      for (int i = 0; i < 8; i++) send_char(8'(i), 1'b0, 1'b0, 1'b0);
      tick(1);
      chk("ovf_full_after_8", 32'(FULL), 32'd1);
      send_char(8'h08, 1'b0, 1'b0, 1'b0);
      tick(1);
      chk("ovf_pulses", 32'(pulse_cnt - p0), 32'd9);
      host_read(4'd1, 8'h23, 1'b1);
      host_read(4'd1, 8'h03, 1'b1);
      for (int i = 0; i < 8; i++) host_read(4'd0, 8'(i), 1'b1);
      tick(1);
      chk("ovf_drained_empty", 32'(EMPTY), 32'd1);

      // simultaneous push and pop while full
      for (int i = 0; i < 8; i++) send_char(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      UART_DATA = 8'h18; RX_STATUS = 1'b1;
      READ_STROBE = 1'b1; PORT_ID = 4'd0;
      exp_q.push_back(8'h10);
      @(negedge CLK);
      RX_STATUS = 1'b0; READ_STROBE = 1'b0;
      chk("simul_full", 32'(FULL), 32'd1);
      host_read(4'd1, 8'h03, 1'b1);
      for (int i = 1; i < 9; i++) host_read(4'd0, 8'h10 + 8'(i), 1'b1);
      tick(1);
      chk("simul_empty", 32'(EMPTY), 32'd1);

      // strobe to an unused port leaves everything alone
      send_char(8'h77, 1'b0, 1'b0, 1'b0);
      host_read(4'd5, 8'h00, 1'b0);
      tick(1);
      chk("other_port_rd_data", 32'(RD_DATA), 32'h18);
      chk("other_port_empty", 32'(EMPTY), 32'd0);

      // reset with 3 entries held, colliding with capture and read
      send_char(8'h78, 1'b0, 1'b0, 1'b0);
      send_char(8'h79, 1'b0, 1'b0, 1'b0);
      tick(1);
      p0 = pulse_cnt;
      @(negedge CLK);
      RESET = 1'b1; RX_STATUS = 1'b1; UART_DATA = 8'h99;
      READ_STROBE = 1'b1; PORT_ID = 4'd0;
      @(negedge CLK);
      READ_STROBE = 1'b0;
      chk("midreset_empty", 32'(EMPTY), 32'd1);
      chk("midreset_rd_data", 32'(RD_DATA), 32'h00);
      tick(1);
      RESET = 1'b0;
      tick(3);
      chk("midreset_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      chk("midreset_still_empty", 32'(EMPTY), 32'd1);
      RX_STATUS = 1'b0;

      send_char(8'h42, 1'b0, 1'b0, 1'b1);
      host_read(4'd1, 8'h11, 1'b1);
      host_read(4'd0, 8'h42, 1'b1);

      chk("pulse_width", 32'(pulse_max), 32'd1);

      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
         tick(1);
         budget--;
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
